ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised bank of WIDTH single-bit storage channels sharing one clock, selectable at run time between SR, JK, D and T flip-flop behaviour. It is the general-purpose successor to the single SR flip-flop and serves as the state-holding primitive for counters, flag registers and small control FSMs in the flip-flop library. Unlike the plain SR cell, it defines the S=R=1 case: the channel holds its value and a sticky per-channel conflict flag is raised, optionally with a saturating conflict-event counter.

## Interface
- WIDTH, 8: number of independent channels (≥1).
- RST_VAL, 1'b0: reset value of every q bit.
- CNT_W, 8: conflict counter width (≥2). Used only when the counter is compiled in.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global update enable; 0 = all channels hold.
- mode_in  in  2  mode to load: 00 SR, 01 JK, 10 D, 11 T.
- mode_ld  in  1  load mode_in into mode_q at the next rising edge.
- a  in  WIDTH  per-channel S / J / D / T input.
- b  in  WIDTH  per-channel R / K input. Ignored in D and T modes.
- clr_conflict  in  1  clear the sticky conflict flags and the counter.
- q  out  WIDTH  registered channel state.
- qbar  out  WIDTH  always ~q. Combinational from q.
- mode_q  out  2  active mode register.
- conflict  out  WIDTH  sticky per-channel flag: an SR S=R=1 event occurred.
- conflict_any  out  1  OR-reduction of conflict.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles. Only present with FF_BANK_CONFLICT_CNT_EN.

## Operation
- Reset (rst=1 at an edge) has priority over everything else:
  - q={WIDTH{RST_VAL}}, qbar=~q.
  - mode_q=00 (SR).
  - conflict=0, conflict_cnt=0.
- When en=1, each channel i updates at the edge according to mode_q (the mode before any same-cycle load):
  - SR: a=1,b=0 → 1. a=0,b=1 → 0. a=0,b=0 → hold. a=1,b=1 → hold, and conflict[i] is set.
  - JK: 10 → 1. 01 → 0. 00 → hold. 11 → toggle.
  - D: q[i]=a[i].
  - T: a[i]=1 → toggle. a[i]=0 → hold.
- When en=0, q holds and no conflicts are detected. mode_ld and clr_conflict still act.
- mode_ld=1: mode_q takes mode_in at the edge. The new mode governs updates from the following edge onward.
- Conflict flags are sticky until clr_conflict or rst.
  - clr_conflict together with a new conflict in the same cycle: the new conflict bit ends set and all other bits clear.
- conflict_cnt (when compiled in):
  - Increments by 1 per edge in which at least one channel detects a conflict, regardless of how many channels conflict.
  - Saturates at 2^CNT_W−1.
  - clr_conflict clears it to 0. If a conflict occurs in the same cycle as the clear, the result is 1.

## Timing
- All state updates on the rising clk edge. Latency from inputs to q is 1 cycle.
- qbar and conflict_any are combinational from registers, with no added latency.
- No handshake. Inputs are sampled every edge and must meet setup/hold.
- Reset mid-operation overrides en, mode_ld and clr_conflict in that cycle. The first functional update occurs at the edge after rst deasserts.

## Configuration
- FF_BANK_CONFLICT_CNT_EN defined:
  - conflict_cnt port and the CNT_W-bit saturating counter are present.
- Not defined:
  - Port and counter are omitted and CNT_W is unused.
  - Sticky conflict flags and conflict_any remain.

## Test plan
- Reset and SR, WIDTH=4, RST_VAL=0:
  - rst for 1 cycle → q=0000, qbar=1111, mode_q=00.
  - Then en=1, a=0101, b=1010 → next edge q=0101.
- SR conflict: from q=0101, apply a=1111, b=1100 → q=0111, conflict=1100, conflict_any=1, conflict_cnt=1.
  - Repeat 2 more cycles → q unchanged, conflict_cnt=3.
- JK/T mode switch:
  - mode_in=01 with mode_ld=1 and a=1111, b=0000 in the same cycle → update uses SR, so q=1111, then mode_q=01.
  - Next cycle a=b=1111 → q=0000.
  - Then load mode 11; with a=0011 for 2 cycles → q=0011, then 0000.
- Enable and D mode: mode 10, en=0, a=1010 → q holds. Then en=1 → q=1010 next edge.
- Clear collision: a conflict on bit 0 in the same cycle as clr_conflict, with prior conflict=1100 and conflict_cnt=5 → conflict=0001, conflict_cnt=1.
- Saturation and mid-operation reset, CNT_W=2:
  - 5 consecutive conflict cycles → conflict_cnt=3, with no wrap.
  - rst asserted together with mode_ld=1 and clr_conflict=1 → all outputs at their reset values, mode_q=00.

Source files
------------

// File: rtl/ff_bank.sv
// ff_bank: WIDTH-channel SR/JK/D/T flip-flop bank with sticky SR conflict flags.
// Define FF_BANK_CONFLICT_CNT_EN to add the saturating conflict_cnt counter.
module ff_bank #(
  parameter int   WIDTH   = 8,
  parameter logic RST_VAL = 1'b0,
  parameter int   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode_in,
  input  logic             mode_ld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [1:0]       mode_q,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
`ifdef FF_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  if (CNT_W < 2) begin : g_cnt_w_too_small
  end

  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] hit;

  // SR with S=R=1 holds and flags; JK uses the J~Q + ~KQ form
  always_comb begin
    q_nx = q;
    hit  = '0;
    if (en) begin
      unique case (mode_q)
        M_SR: begin
          q_nx = (q & ~(b & ~a)) | (a & ~b);
          hit  = a & b;
        end
        M_JK:    q_nx = (a & ~q) | (~b & q);
        M_D:     q_nx = a;
        M_T:     q_nx = q ^ a;
        default: q_nx = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= {WIDTH{RST_VAL}};
      mode_q   <= M_SR;
      conflict <= '0;
    end else begin
      q <= q_nx;
      if (mode_ld) mode_q <= mode_in;
      conflict <= clr_conflict ? hit : (conflict | hit);
    end
  end

  assign qbar         = ~q;
  assign conflict_any = |conflict;

`ifdef FF_BANK_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_conflict) begin
      conflict_cnt <= (|hit) ? CNT_ONE : '0;
    end else if ((|hit) && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed and random checks of ff_bank against a per-bit model.
// Counter checks are active when FF_BANK_CONFLICT_CNT_EN is defined.
module tb_ff_bank;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst, en, mode_ld, clr_conflict;
  logic [1:0]   mode_in;
  logic [W-1:0] a, b;
  logic [W-1:0] q, qbar, conflict;
  logic [1:0]   mode_q;
  logic         conflict_any;
`ifdef FF_BANK_CONFLICT_CNT_EN
  logic [CW-1:0] conflict_cnt;
`endif

  ff_bank #(.WIDTH(W), .RST_VAL(1'b0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in),
    .mode_ld(mode_ld), .a(a), .b(b), .clr_conflict(clr_conflict),
    .q(q), .qbar(qbar), .mode_q(mode_q), .conflict(conflict),
    .conflict_any(conflict_any)
`ifdef FF_BANK_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  bit       mq   [W];
  bit       mc   [W];
  int       mmode;
  int       mcnt;

  function automatic logic [W-1:0] pack_q();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mq[i];
    return v;
  endfunction

  function automatic logic [W-1:0] pack_c();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mc[i];
    return v;
  endfunction

  task automatic model_edge();
    bit newc [W];
    bit anyc;
    anyc = 0;
    if (rst) begin
      for (int i = 0; i < W; i++) begin mq[i] = 0; mc[i] = 0; end
      mmode = 0;
      mcnt  = 0;
      return;
    end
    for (int i = 0; i < W; i++) begin
      bit s, r;
      s = a[i];
      r = b[i];
      newc[i] = 0;
      if (en) begin
        case (mmode)
          0: if (s && r) newc[i] = 1;
             else if (s) mq[i] = 1;
             else if (r) mq[i] = 0;
          1: if (s && r) mq[i] = !mq[i];
             else if (s) mq[i] = 1;
             else if (r) mq[i] = 0;
          2: mq[i] = s;
          default: if (s) mq[i] = !mq[i];
        endcase
      end
      if (newc[i]) anyc = 1;
    end
    for (int i = 0; i < W; i++)
      mc[i] = clr_conflict ? newc[i] : (mc[i] | newc[i]);
    if (clr_conflict) mcnt = anyc ? 1 : 0;
    else if (anyc && mcnt < CMAX) mcnt = mcnt + 1;
    if (mode_ld) mmode = int'(mode_in);
  endtask

  task automatic cyc(input logic r_, input logic en_, input logic [1:0] mi,
                     input logic ld, input logic [W-1:0] a_, input logic [W-1:0] b_,
                     input logic clr);
    rst = r_; en = en_; mode_in = mi; mode_ld = ld;
    a = a_; b = b_; clr_conflict = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 2'b00, 0, '0, '0, 0);
    n_checks++;
    if (q !== 4'b0000) begin
      n_fail++; $display("FAIL reset_q got %b want %b", q, 4'b0000);
    end
    n_checks++;
    if (qbar !== 4'b1111) begin
      n_fail++; $display("FAIL reset_qbar got %b want %b", qbar, 4'b1111);
    end
    n_checks++;
    if (mode_q !== 2'b00 || conflict !== 4'b0000 || conflict_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got mode=%b conf=%b any=%b want 00 0000 0",
               mode_q, conflict, conflict_any);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
    end
`endif
  endtask

  task automatic test_sr();
    cyc(0, 1, 2'b00, 0, 4'b0101, 4'b1010, 0);
    n_checks++;
    if (q !== 4'b0101) begin
      n_fail++; $display("FAIL sr_set_reset got %b want %b", q, 4'b0101);
    end
  endtask

  task automatic test_conflict();
    cyc(0, 1, 2'b00, 0, 4'b1111, 4'b1100, 0);
    n_checks++;
    if (q !== 4'b0111 || conflict !== 4'b1100 || conflict_any !== 1'b1) begin
      n_fail++;
      $display("FAIL sr_conflict got q=%b conf=%b any=%b want 0111 1100 1",
               q, conflict, conflict_any);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 3'd1) begin
      n_fail++; $display("FAIL conflict_cnt1 got %0d want 1", conflict_cnt);
    end
`endif
    repeat (2) cyc(0, 1, 2'b00, 0, 4'b1111, 4'b1100, 0);
    n_checks++;
    if (q !== 4'b0111 || conflict !== 4'b1100) begin
      n_fail++; $display("FAIL conflict_hold got q=%b conf=%b want 0111 1100", q, conflict);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 3'd3) begin
      n_fail++; $display("FAIL conflict_cnt3 got %0d want 3", conflict_cnt);
    end
`endif
  endtask

  task automatic test_mode_switch();
    cyc(0, 1, 2'b01, 1, 4'b1111, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b1111 || mode_q !== 2'b01) begin
      n_fail++; $display("FAIL load_jk got q=%b mode=%b want 1111 01", q, mode_q);
    end
    cyc(0, 1, 2'b00, 0, 4'b1111, 4'b1111, 0);
    n_checks++;
    if (q !== 4'b0000) begin
      n_fail++; $display("FAIL jk_toggle got %b want 0000", q);
    end
    cyc(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b0000 || mode_q !== 2'b11) begin
      n_fail++; $display("FAIL load_t got q=%b mode=%b want 0000 11", q, mode_q);
    end
    cyc(0, 1, 2'b00, 0, 4'b0011, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b0011) begin
      n_fail++; $display("FAIL t_toggle1 got %b want 0011", q);
    end
    cyc(0, 1, 2'b00, 0, 4'b0011, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b0000) begin
      n_fail++; $display("FAIL t_toggle2 got %b want 0000", q);
    end
  endtask

  task automatic test_enable_d();
    cyc(0, 0, 2'b10, 1, 4'b1010, 4'b0000, 0);
    cyc(0, 0, 2'b00, 0, 4'b1010, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b0000 || mode_q !== 2'b10) begin
      n_fail++; $display("FAIL en_hold got q=%b mode=%b want 0000 10", q, mode_q);
    end
    cyc(0, 1, 2'b00, 0, 4'b1010, 4'b0000, 0);
    n_checks++;
    if (q !== 4'b1010) begin
      n_fail++; $display("FAIL d_load got %b want 1010", q);
    end
  endtask

  task automatic test_clear_collision();
    cyc(0, 0, 2'b00, 1, 4'b0000, 4'b0000, 0);
    repeat (2) cyc(0, 1, 2'b00, 0, 4'b1100, 4'b1100, 0);
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 3'd5) begin
      n_fail++; $display("FAIL pre_clear_cnt got %0d want 5", conflict_cnt);
    end
`endif
    cyc(0, 1, 2'b00, 0, 4'b0001, 4'b0001, 1);
    n_checks++;
    if (conflict !== 4'b0001) begin
      n_fail++; $display("FAIL clear_collision got %b want 0001", conflict);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 3'd1) begin
      n_fail++; $display("FAIL clear_collision_cnt got %0d want 1", conflict_cnt);
    end
`endif
  endtask

  task automatic test_saturation();
    repeat (CMAX + 3) cyc(0, 1, 2'b00, 0, 4'b0010, 4'b0010, 0);
    n_checks++;
    if (conflict !== 4'b0011) begin
      n_fail++; $display("FAIL sat_flags got %b want 0011", conflict);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 3'd7) begin
      n_fail++; $display("FAIL saturation got %0d want 7", conflict_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    cyc(0, 1, 2'b00, 0, 4'b1101, 4'b0000, 0);
    cyc(1, 1, 2'b11, 1, 4'b1111, 4'b1111, 1);
    n_checks++;
    if (q !== 4'b0000 || qbar !== 4'b1111 || mode_q !== 2'b00 ||
        conflict !== 4'b0000 || conflict_any !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got q=%b qbar=%b mode=%b conf=%b any=%b want 0000 1111 00 0000 0",
               q, qbar, mode_q, conflict, conflict_any);
    end
`ifdef FF_BANK_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset_cnt got %0d want 0", conflict_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
          W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0));
      n_checks++;
      if (q !== pack_q() || qbar !== ~pack_q() || mode_q !== 2'(mmode)) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d got q=%b qbar=%b mode=%b want %b %b %b",
                 n, q, qbar, mode_q, pack_q(), ~pack_q(), 2'(mmode));
      end
      n_checks++;
      if (conflict !== pack_c() || conflict_any !== (|pack_c())) begin
        n_fail++;
        $display("FAIL rand_conflict cyc %0d got %b/%b want %b/%b",
                 n, conflict, conflict_any, pack_c(), |pack_c());
      end
`ifdef FF_BANK_CONFLICT_CNT_EN
      n_checks++;
      if (conflict_cnt !== CW'(mcnt)) begin
        n_fail++;
        $display("FAIL rand_cnt cyc %0d got %0d want %0d", n, conflict_cnt, mcnt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1; en = 0; mode_in = 0; mode_ld = 0;
    a = 0; b = 0; clr_conflict = 0;
    mmode = 0; mcnt = 0;
    for (int i = 0; i < W; i++) begin mq[i] = 0; mc[i] = 0; end
    test_reset();
    test_sr();
    test_conflict();
    test_mode_switch();
    test_enable_d();
    test_clear_collision();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
